// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the RV64 core, downstream of the execute-stage ALU.
// Non-memory ops pass the ALU result straight to writeback one cycle after acceptance.
// Loads/stores are checked for alignment and legal size, then run a req/gnt/rvalid
// handshake on the data-memory port before a single registered writeback beat.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ex_valid/ex_ready               instruction handshake from execute
//   ex_result/ex_wdata              ALU result (address or value), store data
//   ex_is_mem/ex_op/ex_rd/ex_we     decode info: mem op, {store,funct3}, rd, write enable
//   dmem_req/we/addr/wdata/wmask    data-memory request, held until dmem_gnt
//   dmem_gnt/dmem_rvalid/dmem_rdata data-memory accept and read return
//   wb_valid/we/rd/data/fault       one-cycle writeback beat
module mem_access_stage #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned MEM_BYTES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [XLEN-1:0]      ex_result,
  input  logic [XLEN-1:0]      ex_wdata,
  input  logic                 ex_is_mem,
  input  logic [3:0]           ex_op,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_we,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [XLEN-1:0]      dmem_wdata,
  output logic [MEM_BYTES-1:0] dmem_wmask,
  input  logic                 dmem_gnt,
  input  logic                 dmem_rvalid,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic                 wb_valid,
  output logic                 wb_we,
  output logic [4:0]           wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 wb_fault
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitR} state_e;

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        addr_q, addr_d;
  logic [3:0]             op_q, op_d;
  logic [4:0]             rd_q, rd_d;
  logic [XLEN-1:0]        wdata_q, wdata_d;
  logic [MEM_BYTES-1:0]   wmask_q, wmask_d;
  logic                   wb_valid_q, wb_valid_d;
  logic                   wb_we_q, wb_we_d;
  logic [4:0]             wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]        wb_data_q, wb_data_d;
  logic                   wb_fault_q, wb_fault_d;

  logic [2:0]             ex_off;
  logic                   ex_fault;
  logic [MEM_BYTES-1:0]   store_mask;
  logic [XLEN-1:0]        lane;
  logic [XLEN-1:0]        load_ext;

  assign ex_off = ex_result[2:0];

  // Illegal sizes and misalignment are both reported as a fault with no memory access.
  always_comb begin
    ex_fault = 1'b0;
    if (ex_op[3] && ex_op[2]) ex_fault = 1'b1;
    if (!ex_op[3] && ex_op[2:0] == 3'b111) ex_fault = 1'b1;
    unique case (ex_op[1:0])
      2'b01:   if (ex_off[0] != 1'b0) ex_fault = 1'b1;
      2'b10:   if (ex_off[1:0] != 2'b00) ex_fault = 1'b1;
      2'b11:   if (ex_off != 3'b000) ex_fault = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    unique case (ex_op[1:0])
      2'b00:   store_mask = MEM_BYTES'(8'h01) << ex_off;
      2'b01:   store_mask = MEM_BYTES'(8'h03) << ex_off;
      2'b10:   store_mask = MEM_BYTES'(8'h0F) << ex_off;
      default: store_mask = MEM_BYTES'(8'hFF);
    endcase
  end

  // Bring the addressed byte lane down to bit 0, then extend per funct3.
  assign lane = dmem_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    case (op_q[2:0])
      3'b000:  load_ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b010:  load_ext = {{(XLEN-32){lane[31]}}, lane[31:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, lane[15:0]};
      3'b110:  load_ext = {{(XLEN-32){1'b0}}, lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    op_d       = op_q;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_fault_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    unique case (state_q)
      StIdle: begin
        if (ex_valid) begin
          if (!ex_is_mem) begin
            wb_valid_d = 1'b1;
            wb_we_d    = ex_we && (ex_rd != 5'd0);
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_result;
          end else if (ex_fault) begin
            wb_valid_d = 1'b1;
            wb_fault_d = 1'b1;
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_result;
          end else begin
            addr_d  = ex_result;
            op_d    = ex_op;
            rd_d    = ex_rd;
            wdata_d = ex_wdata << {ex_off, 3'b000};
            wmask_d = ex_op[3] ? store_mask : '0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (dmem_gnt) begin
          if (op_q[3]) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = '0;
            state_d    = StIdle;
          end else begin
            state_d = StWaitR;
          end
        end
      end
      StWaitR: begin
        if (dmem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_we_d    = (rd_q != 5'd0);
          wb_rd_d    = rd_q;
          wb_data_d  = load_ext;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_fault_q <= wb_fault_d;
    end
  end

  // Gated by rst_n so every output reads 0 while reset is held.
  assign ex_ready   = (state_q == StIdle) && rst_n;
  assign dmem_req   = (state_q == StReq);
  assign dmem_we    = op_q[3];
  assign dmem_addr  = {addr_q[XLEN-1:3], 3'b000};
  assign dmem_wdata = wdata_q;
  assign dmem_wmask = wmask_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign wb_fault   = wb_fault_q;

endmodule
